// File: rtl/timer_pkg.sv
// Shared types and limits for the mm:ss stopwatch: FSM encoding, BCD digit limits, WRAP modes.
// Pure declarations; no timing of its own.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LIMIT = 2'd3
    } state_t;

    localparam int SEC_TENS_MAX = 5;
    localparam int UNITS_MAX    = 9;
    localparam int MIN_TENS_MAX = 5;

    localparam int WRAP_SATURATE = 0;
    localparam int WRAP_ROLLOVER = 1;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_units;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
    } mmss_t;

    function automatic logic is_max(input mmss_t t);
        return (t.min_tens  == 4'(MIN_TENS_MAX)) &&
               (t.min_units == 4'(UNITS_MAX))    &&
               (t.sec_tens  == 4'(SEC_TENS_MAX)) &&
               (t.sec_units == 4'(UNITS_MAX));
    endfunction

endpackage

// File: rtl/cronometro_minseg_if.sv
// Command pulses in, BCD display digits and status flags out, for the mm:ss stopwatch.
// Plain wires; no flow control, every command is a single-cycle pulse.
interface cronometro_minseg_if;

    logic       tick;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       running;
    logic       lap_active;
    logic       overflow;

    modport master (
        output tick, start_stop, lap, clear,
        input  min_tens, min_units, sec_tens, sec_units,
        input  running, lap_active, overflow
    );

    modport slave (
        input  tick, start_stop, lap, clear,
        output min_tens, min_units, sec_tens, sec_units,
        output running, lap_active, overflow
    );

endinterface

// File: rtl/contador_up_bcd.sv
// Single modulo-MOD up counter digit with synchronous clear; carry is combinational (en at last value).
// Count visible one cycle after en; no backpressure.
module contador_up_bcd #(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] LAST = 4'(MOD - 1);

    logic [3:0] r_q;

    // The >= guard keeps the digit in range even from an out-of-range value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= (r_q >= LAST) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign q     = r_q;
    assign carry = en && (r_q == LAST);

endmodule

// File: rtl/cronometro_minseg.sv
// mm:ss stopwatch: start/pause FSM, four chained BCD digits, lap freeze, saturate or roll at 59:59.
// Tick lands on the display one cycle later; no backpressure, commands are one-cycle pulses.
module cronometro_minseg
    import timer_pkg::*;
#(
    parameter int WRAP = WRAP_SATURATE
) (
    input  logic                clk,
    input  logic                rst,
    cronometro_minseg_if.slave  bus
);

    state_t     r_state;
    mmss_t      r_lap;
    logic       r_lap_active;
    logic       r_overflow;

    mmss_t      w_live;
    mmss_t      w_disp;
    logic [3:0] w_su;
    logic [3:0] w_st;
    logic [3:0] w_mu;
    logic [3:0] w_mt;
    logic       w_c_su;
    logic       w_c_st;
    logic       w_c_mu;
    logic       w_c_mt;
    logic       w_tick_run;
    logic       w_at_max;
    logic       w_inc;

    assign w_live     = '{min_tens: w_mt, min_units: w_mu, sec_tens: w_st, sec_units: w_su};
    assign w_at_max   = is_max(w_live);
    assign w_tick_run = bus.tick && (r_state == ST_RUN) && !bus.clear;
    // In saturate mode the tick at 59:59 must not reach the digits at all.
    assign w_inc      = w_tick_run && ((WRAP != WRAP_SATURATE) || !w_at_max);

    contador_up_bcd #(.MOD(UNITS_MAX + 1)) u_sec_units (
        .clk(clk), .rst(rst), .en(w_inc),  .clr(bus.clear), .q(w_su), .carry(w_c_su)
    );
    contador_up_bcd #(.MOD(SEC_TENS_MAX + 1)) u_sec_tens (
        .clk(clk), .rst(rst), .en(w_c_su), .clr(bus.clear), .q(w_st), .carry(w_c_st)
    );
    contador_up_bcd #(.MOD(UNITS_MAX + 1)) u_min_units (
        .clk(clk), .rst(rst), .en(w_c_st), .clr(bus.clear), .q(w_mu), .carry(w_c_mu)
    );
    contador_up_bcd #(.MOD(MIN_TENS_MAX + 1)) u_min_tens (
        .clk(clk), .rst(rst), .en(w_c_mu), .clr(bus.clear), .q(w_mt), .carry(w_c_mt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lap        <= '0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (bus.clear) begin
            r_state      <= ST_IDLE;
            r_lap        <= '0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Roll-over mode: the top carry is exactly the 59:59 -> 00:00 event.
            if (WRAP != WRAP_SATURATE) begin
                r_overflow <= w_c_mt;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start_stop) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_tick_run && w_at_max && (WRAP == WRAP_SATURATE)) begin
                        r_state    <= ST_LIMIT;
                        r_overflow <= 1'b1;
                    end else if (bus.start_stop) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_stop) r_state <= ST_RUN;
                end
                ST_LIMIT: begin
                    r_state <= ST_LIMIT;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Capture uses the registered live count, i.e. before any coincident tick.
            if (bus.lap) begin
                if (r_lap_active) begin
                    r_lap_active <= 1'b0;
                end else if ((r_state == ST_RUN) || (r_state == ST_PAUSE)) begin
                    r_lap        <= w_live;
                    r_lap_active <= 1'b1;
                end
            end
        end
    end

    assign w_disp         = r_lap_active ? r_lap : w_live;
    assign bus.min_tens   = w_disp.min_tens;
    assign bus.min_units  = w_disp.min_units;
    assign bus.sec_tens   = w_disp.sec_tens;
    assign bus.sec_units  = w_disp.sec_units;
    assign bus.running    = (r_state == ST_RUN);
    assign bus.lap_active = r_lap_active;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_cronometro_minseg.sv
// Directed bench: a saturating and a rolling stopwatch get identical command streams.
// Observed word is {mm:ss BCD, running, lap_active, overflow}.
module tb_cronometro_minseg;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cronometro_minseg_if ifs ();
    cronometro_minseg_if ifw ();

    cronometro_minseg #(.WRAP(0)) dut_sat (
        .clk(clk), .rst(rst), .bus(ifs.slave)
    );
    cronometro_minseg #(.WRAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .bus(ifw.slave)
    );

    logic [18:0] obs_s;
    logic [18:0] obs_w;
    assign obs_s = {ifs.min_tens, ifs.min_units, ifs.sec_tens, ifs.sec_units,
                    ifs.running, ifs.lap_active, ifs.overflow};
    assign obs_w = {ifw.min_tens, ifw.min_units, ifw.sec_tens, ifw.sec_units,
                    ifw.running, ifw.lap_active, ifw.overflow};

    // Drive one clock's worth of command pulses from a negedge, return at the next negedge.
    task automatic cyc(input logic tk, input logic ss, input logic lp, input logic cl);
        ifs.tick = tk; ifs.start_stop = ss; ifs.lap = lp; ifs.clear = cl;
        ifw.tick = tk; ifw.start_stop = ss; ifw.lap = lp; ifw.clear = cl;
        @(negedge clk);
        ifs.tick = 1'b0; ifs.start_stop = 1'b0; ifs.lap = 1'b0; ifs.clear = 1'b0;
        ifw.tick = 1'b0; ifw.start_stop = 1'b0; ifw.lap = 1'b0; ifw.clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        total++;
        if (obs_s !== 19'h0) begin
            bad++; $display("FAIL reset_sat: got %h/%b want 0000/000", obs_s[18:3], obs_s[2:0]);
        end
        total++;
        if (obs_w !== 19'h0) begin
            bad++; $display("FAIL reset_wrap: got %h/%b want 0000/000", obs_w[18:3], obs_w[2:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL idle_tick_lap: got %h/%b want 0000/000", obs_s[18:3], obs_s[2:0]);
        end
    endtask

    task automatic test_count();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== {16'h0000, 3'b100}) begin
            bad++; $display("FAIL start: got %h/%b want 0000/100", obs_s[18:3], obs_s[2:0]);
        end
        ticks(1);
        total++;
        if (obs_s !== {16'h0001, 3'b100}) begin
            bad++; $display("FAIL first_tick: got %h/%b want 0001/100", obs_s[18:3], obs_s[2:0]);
        end
        ticks(74);
        total++;
        if (obs_s !== {16'h0115, 3'b100}) begin
            bad++; $display("FAIL count_75: got %h/%b want 0115/100", obs_s[18:3], obs_s[2:0]);
        end
        total++;
        if (obs_w !== {16'h0115, 3'b100}) begin
            bad++; $display("FAIL count_75_wrap: got %h/%b want 0115/100", obs_w[18:3], obs_w[2:0]);
        end
    endtask

    task automatic test_pause();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs_s !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL clear_idle: got %h/%b want 0000/000", obs_s[18:3], obs_s[2:0]);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== {16'h0010, 3'b000}) begin
            bad++; $display("FAIL run_ss_tick: got %h/%b want 0010/000", obs_s[18:3], obs_s[2:0]);
        end
        ticks(3);
        total++;
        if (obs_s !== {16'h0010, 3'b000}) begin
            bad++; $display("FAIL paused_ticks: got %h/%b want 0010/000", obs_s[18:3], obs_s[2:0]);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== {16'h0010, 3'b100}) begin
            bad++; $display("FAIL pause_ss_tick: got %h/%b want 0010/100", obs_s[18:3], obs_s[2:0]);
        end
        ticks(1);
        total++;
        if (obs_s !== {16'h0011, 3'b100}) begin
            bad++; $display("FAIL resume_tick: got %h/%b want 0011/100", obs_s[18:3], obs_s[2:0]);
        end
    endtask

    task automatic test_lap();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(150);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== {16'h0230, 3'b110}) begin
            bad++; $display("FAIL lap_capture: got %h/%b want 0230/110", obs_s[18:3], obs_s[2:0]);
        end
        ticks(20);
        total++;
        if (obs_s !== {16'h0230, 3'b110}) begin
            bad++; $display("FAIL lap_frozen: got %h/%b want 0230/110", obs_s[18:3], obs_s[2:0]);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== {16'h0250, 3'b100}) begin
            bad++; $display("FAIL lap_release: got %h/%b want 0250/100", obs_s[18:3], obs_s[2:0]);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== {16'h0250, 3'b110}) begin
            bad++; $display("FAIL lap_pre_inc: got %h/%b want 0250/110", obs_s[18:3], obs_s[2:0]);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== {16'h0251, 3'b100}) begin
            bad++; $display("FAIL lap_live_kept: got %h/%b want 0251/100", obs_s[18:3], obs_s[2:0]);
        end
    endtask

    task automatic test_clear_tick();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs_s !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL clear_with_tick: got %h/%b want 0000/000", obs_s[18:3], obs_s[2:0]);
        end
    endtask

    task automatic test_limit();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3599);
        total++;
        if (obs_s !== {16'h5959, 3'b100}) begin
            bad++; $display("FAIL reach_5959: got %h/%b want 5959/100", obs_s[18:3], obs_s[2:0]);
        end
        ticks(1);
        total++;
        if (obs_s !== {16'h5959, 3'b001}) begin
            bad++; $display("FAIL saturate: got %h/%b want 5959/001", obs_s[18:3], obs_s[2:0]);
        end
        total++;
        if (obs_w !== {16'h0000, 3'b101}) begin
            bad++; $display("FAIL rollover: got %h/%b want 0000/101", obs_w[18:3], obs_w[2:0]);
        end
        ticks(1);
        total++;
        if (obs_s !== {16'h5959, 3'b001}) begin
            bad++; $display("FAIL saturate_hold: got %h/%b want 5959/001", obs_s[18:3], obs_s[2:0]);
        end
        total++;
        if (obs_w !== {16'h0001, 3'b100}) begin
            bad++; $display("FAIL ovf_one_cycle: got %h/%b want 0001/100", obs_w[18:3], obs_w[2:0]);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== {16'h5959, 3'b001}) begin
            bad++; $display("FAIL limit_ignores: got %h/%b want 5959/001", obs_s[18:3], obs_s[2:0]);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs_s !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL limit_clear: got %h/%b want 0000/000", obs_s[18:3], obs_s[2:0]);
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(754);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2);
        total++;
        if (obs_s !== {16'h1234, 3'b110}) begin
            bad++; $display("FAIL pre_rst_lap: got %h/%b want 1234/110", obs_s[18:3], obs_s[2:0]);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs_s !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL async_rst: got %h/%b want 0000/000", obs_s[18:3], obs_s[2:0]);
        end
        total++;
        if (obs_w !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL async_rst_wrap: got %h/%b want 0000/000", obs_w[18:3], obs_w[2:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_s !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL post_rst_idle: got %h/%b want 0000/000", obs_s[18:3], obs_s[2:0]);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        total++;
        if (obs_s !== {16'h0001, 3'b100}) begin
            bad++; $display("FAIL post_rst_run: got %h/%b want 0001/100", obs_s[18:3], obs_s[2:0]);
        end
    endtask

    initial begin
        ifs.tick = 1'b0; ifs.start_stop = 1'b0; ifs.lap = 1'b0; ifs.clear = 1'b0;
        ifw.tick = 1'b0; ifw.start_stop = 1'b0; ifw.lap = 1'b0; ifw.clear = 1'b0;
        test_reset();
        test_count();
        test_pause();
        test_lap();
        test_clear_tick();
        test_limit();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cronometro_minseg.md
CRONOMETRO_MINSEG -- requirements
Module: cronometro_minseg

Interface
REQ-001 SHALL have parameter WRAP, default 0: 0 = saturate at 59:59; 1 = roll over to 00:00.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port tick, input, 1, one-cycle 1 Hz count-enable pulse.
REQ-005 SHALL have port start_stop, input, 1, one-cycle command pulse.
REQ-006 SHALL have port lap, input, 1, one-cycle command pulse.
REQ-007 SHALL have port clear, input, 1, one-cycle synchronous clear pulse.
REQ-008 SHALL have ports min_tens, min_units, sec_tens and sec_units, each output, 4 bits, BCD display digits.
REQ-009 SHALL have port running, output, 1, high while the state is RUN.
REQ-010 SHALL have port lap_active, output, 1, high while the display is frozen.
REQ-011 SHALL have port overflow, output, 1, flag for the 59:59 limit.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSE and LIMIT.
REQ-013 SHALL apply these start_stop transitions: IDLE->RUN; RUN->PAUSE; PAUSE->RUN; ignored in LIMIT.
REQ-014 SHALL keep a live count of 4 BCD digits: sec_units 0-9, sec_tens 0-5, min_units 0-9, min_tens 0-5.
REQ-015 SHALL increment the live count by 1 s only when tick=1 and the current state is RUN; the new value is visible the next cycle (latency 1).
REQ-016 SHALL apply digit carries: sec_units 9->0 carries into sec_tens; sec_tens 5->0 carries into min_units; min_units 9->0 carries into min_tens.
REQ-017 SHALL, with WRAP=0 and tick at 59:59 in RUN, hold 59:59, enter LIMIT and set overflow=1 until clear or rst.
REQ-018 SHALL, with WRAP=1 and tick at 59:59 in RUN, go to 00:00, stay in RUN and pulse overflow high for exactly 1 cycle.
REQ-019 SHALL, when start_stop and tick coincide in RUN, count the tick and then enter PAUSE.
REQ-020 SHALL, when start_stop and tick coincide in PAUSE, not count the tick and enter RUN.
REQ-021 SHALL, on lap in RUN or PAUSE with lap_active=0, capture the pre-increment live count into the lap register and set lap_active=1.
REQ-022 SHALL, on lap with lap_active=1 in any state, clear lap_active.
REQ-023 SHALL ignore lap in IDLE, and ignore lap in LIMIT when lap_active=0.
REQ-024 SHALL drive the digit outputs from the lap register when lap_active=1, else from the live count; the live count keeps counting while lap_active=1.
REQ-025 SHALL, on clear, in any state: count=00:00, lap register=0, lap_active=0, overflow=0, state=IDLE, effective next cycle.
REQ-026 SHALL apply priority clear > start_stop/lap > tick; clear together with tick yields 00:00 (no count).
REQ-027 SHALL drive running combinationally from the registered state.
REQ-028 SHALL never let any digit leave its BCD range, for any input sequence.

Reset
REQ-029 SHALL, while rst=1, immediately force state=IDLE, all digits=0, lap register=0, lap_active=0, running=0, overflow=0.
REQ-030 SHALL, on rst mid-count, in LIMIT or with lap_active=1, discard all state; the first edge after release sees IDLE.

Structure
REQ-031 SHALL place the state encodings, the digit limits (SEC_TENS_MAX=5, UNITS_MAX=9, MIN_TENS_MAX=5) and the WRAP semantics constants in shared package timer_pkg.
REQ-032 SHALL instantiate one sub-module per digit, contador_up_bcd, with parameter MOD, inputs clk/rst/en/clr, outputs q[3:0] and carry (carry = en AND q==MOD-1).
REQ-033 SHALL keep the FSM, lap register and output muxing in cronometro_minseg itself.

Verification
REQ-034 SHALL cover basic counting: rst, start_stop, 75 ticks -> display 01:15, running=1.
REQ-035 SHALL cover pause: in RUN at 00:09, start_stop+tick same cycle -> 00:10 and PAUSE; 3 further ticks -> still 00:10, running=0.
REQ-036 SHALL cover lap: at 02:30 lap, then 20 ticks -> display 02:30, lap_active=1; lap again -> display 02:50.
REQ-037 SHALL cover saturation: WRAP=0, counted to 59:59, 2 ticks -> 59:59, overflow=1, start_stop ignored; clear -> 00:00, IDLE, overflow=0.
REQ-038 SHALL cover roll-over: WRAP=1, at 59:59 tick -> 00:00, overflow high for 1 cycle, running=1.
REQ-039 SHALL cover async reset: rst asserted mid-cycle at 12:34 with lap_active=1 -> outputs 00:00 before the next clk edge, lap_active=0.
